// File: rtl/bcd_time_clock.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler and edge-detected hour/minute
// set buttons. Drives the hr/min/sec time bus plus one-cycle second and minute strobes.
module bcd_time_clock #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       addhr,
    input  logic       addmin,
    output logic [7:0] hr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       sec_pulse,
    output logic       min_pulse
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    // Packed-BCD increment that wraps to 00 once the value reaches top.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hr_q, hr_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          min_pulse_q, min_pulse_d;
    logic          addhr_prev_q, addhr_prev_d;
    logic          addmin_prev_q, addmin_prev_d;

    logic hr_ev, min_ev, set_ev, tick;

    always_comb begin
        hr_ev  = addhr & ~addhr_prev_q;
        min_ev = addmin & ~addmin_prev_q;
        set_ev = hr_ev | min_ev;
        tick   = run && (presc_q == PRESC_LAST);

        presc_d       = presc_q;
        hr_d          = hr_q;
        min_d         = min_q;
        sec_d         = sec_q;
        sec_pulse_d   = 1'b0;
        min_pulse_d   = 1'b0;
        addhr_prev_d  = addhr;
        addmin_prev_d = addmin;

        // A set event wins over a coincident tick; the tick is simply dropped.
        if (set_ev) begin
            presc_d = '0;
            sec_d   = 8'h00;
            if (hr_ev) begin
                hr_d = bcd_inc(hr_q, 8'h23);
            end
            if (min_ev) begin
                min_d = bcd_inc(min_q, 8'h59);
            end
        end else if (tick) begin
            presc_d     = '0;
            sec_d       = bcd_inc(sec_q, 8'h59);
            sec_pulse_d = 1'b1;
            if (sec_q == 8'h59) begin
                min_d       = bcd_inc(min_q, 8'h59);
                min_pulse_d = 1'b1;
                if (min_q == 8'h59) begin
                    hr_d = bcd_inc(hr_q, 8'h23);
                end
            end
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            hr_q          <= 8'h00;
            min_q         <= 8'h00;
            sec_q         <= 8'h00;
            sec_pulse_q   <= 1'b0;
            min_pulse_q   <= 1'b0;
            addhr_prev_q  <= 1'b0;
            addmin_prev_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            hr_q          <= hr_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            sec_pulse_q   <= sec_pulse_d;
            min_pulse_q   <= min_pulse_d;
            addhr_prev_q  <= addhr_prev_d;
            addmin_prev_q <= addmin_prev_d;
        end
    end

    assign hr        = hr_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign sec_pulse = sec_pulse_q;
    assign min_pulse = min_pulse_q;

endmodule

// File: tb/tb_bcd_time_clock.sv
// Scoreboard bench for bcd_time_clock at TICKS_PER_SEC=4: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the time bus.
module tb_bcd_time_clock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       addhr = 1'b0;
    logic       addmin = 1'b0;
    logic [7:0] hr, min, sec;
    logic       sec_pulse, min_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        string      name;
        logic [7:0] e_hr;
        logic [7:0] e_min;
        logic [7:0] e_sec;
        logic       e_sp;
        logic       e_mp;
        int         at;
    } exp_t;

    exp_t sb[$];

    bcd_time_clock #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .addhr     (addhr),
        .addmin    (addmin),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .sec_pulse (sec_pulse),
        .min_pulse (min_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (hr !== e.e_hr || min !== e.e_min || sec !== e.e_sec ||
                sec_pulse !== e.e_sp || min_pulse !== e.e_mp) begin
                n_fail++;
                $display("FAIL %s: got %h:%h:%h sp=%b mp=%b, want %h:%h:%h sp=%b mp=%b",
                         e.name, hr, min, sec, sec_pulse, min_pulse,
                         e.e_hr, e.e_min, e.e_sec, e.e_sp, e.e_mp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic sp, input logic mp);
        exp_t e;
        e.name = name; e.e_hr = h; e.e_min = m; e.e_sec = s;
        e.e_sp = sp; e.e_mp = mp; e.at = cyc;
        sb.push_back(e);
    endtask

    task automatic press_hr(input int n);
        for (int i = 0; i < n; i++) begin
            addhr = 1'b1; tick(1);
            addhr = 1'b0; tick(1);
        end
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            addmin = 1'b1; tick(1);
            addmin = 1'b0; tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and 1 Hz stepping: pulses after clk 4 and 8.
        tick(2);
        chk("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0; run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("run8", 8'h00, 8'h00, 8'(k / 4), (k % 4) == 0, 1'b0);
        end

        // run=0 freezes sec and prescaler.
        run = 1'b0;
        tick(50);
        chk("frozen", 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        run = 1'b1;
        tick(3);
        chk("resume_pre", 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        tick(1);
        chk("resume_tick", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
        run = 1'b0;

        // addmin from 07:59 wraps to 00 without carrying into hr.
        press_hr(7);
        press_min(59);
        chk("preload_0759", 8'h07, 8'h59, 8'h00, 1'b0, 1'b0);
        addmin = 1'b1; tick(1);
        chk("min_wrap", 8'h07, 8'h00, 8'h00, 1'b0, 1'b0);
        addmin = 1'b0; tick(1);
        chk("min_wrap_after", 8'h07, 8'h00, 8'h00, 1'b0, 1'b0);

        // Holding addhr yields one step; hr wraps 23 -> 00.
        press_hr(2);
        chk("hr09", 8'h09, 8'h00, 8'h00, 1'b0, 1'b0);
        addhr = 1'b1; tick(20);
        chk("hold_hr", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        addhr = 1'b0; tick(1);
        press_hr(13);
        chk("hr23", 8'h23, 8'h00, 8'h00, 1'b0, 1'b0);
        press_hr(1);
        chk("hr_wrap", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Full day rollover from 23:59:59.
        press_hr(23);
        press_min(59);
        run = 1'b1;
        tick(236);
        chk("at_235959", 8'h23, 8'h59, 8'h59, 1'b1, 1'b0);
        tick(3);
        chk("pre_roll", 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        tick(1);
        chk("rollover", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        tick(4);
        chk("after_roll", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);

        // addmin coinciding with the tick: tick dropped, no pulses.
        tick(3);
        addmin = 1'b1; tick(1);
        chk("set_on_tick", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        addmin = 1'b0; tick(3);
        chk("set_tick_pre", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        tick(1);
        chk("set_tick_next", 8'h00, 8'h01, 8'h01, 1'b1, 1'b0);

        // Set mid-count restarts the prescaler from 0.
        tick(2);
        addmin = 1'b1; tick(1);
        chk("set_mid", 8'h00, 8'h02, 8'h00, 1'b0, 1'b0);
        addmin = 1'b0; tick(3);
        chk("presc_cleared", 8'h00, 8'h02, 8'h00, 1'b0, 1'b0);
        tick(1);
        chk("presc_full_sec", 8'h00, 8'h02, 8'h01, 1'b1, 1'b0);

        // Async reset between clock edges, with a button held through release.
        tick(2);
        #1 rst = 1'b1;
        chk("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        addhr = 1'b1; run = 1'b0;
        tick(2);
        chk("rst_held", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("held_through_rst", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(3);
        chk("held_one_step", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        addhr = 1'b0;
        tick(2);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
